cmd_arb: RTL and testbench

CMD_ARB -- requirements
Module: cmd_arb

---
 rtl/cmd_arb.sv | 96 +++++++++
 tb/tb_cmd_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_arb.sv
// Two-requester command arbiter: round-robin grant, one outstanding command,
// fixed-latency response capture, per-requester response hold until acknowledged.
module cmd_arb #(
  parameter int unsigned RSP_LAT = 1,
  parameter int unsigned ERR_BIT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_cmd0,
  input  logic [31:0] req_cmd1,
  output logic [1:0]  req_ready,
  output logic        run,
  output logic [31:0] cmd,
  input  logic [31:0] rsp,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  input  logic [1:0]  rsp_ack,
  output logic        busy,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT = 4'(RSP_LAT);

  state_t     state;
  logic [3:0] cnt;
  logic       gnt_idx;
  logic       last_gnt;
  logic       pick;

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    pick = 1'b0;
    if (req_valid == 2'b11) pick = ~last_gnt;
    else                    pick = ~req_valid[0];
  end

  // Accept strobe is combinational so the requester sees it in the grant cycle.
  assign req_ready = (state == IDLE && !rst && |req_valid) ?
                     (pick ? 2'b10 : 2'b01) : 2'b00;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      run       <= 1'b0;
      cmd       <= '0;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      err_cnt   <= '0;
      cnt       <= '0;
      last_gnt  <= 1'b1;
      gnt_idx   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt_idx  <= pick;
            last_gnt <= pick;
            cmd      <= pick ? req_cmd1 : req_cmd0;
            run      <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          run   <= 1'b0;
          cnt   <= LAT;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            rsp_data  <= rsp;
            if (rsp[ERR_BIT] && err_cnt != 16'hFFFF)
              err_cnt <= err_cnt + 16'd1;
            rsp_valid <= gnt_idx ? 2'b10 : 2'b01;
            cnt       <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // Only the owner of the outstanding command can retire it.
          if (rsp_ack[gnt_idx]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_arb.sv
// Bench for cmd_arb: timestamp-based transaction model checked every cycle,
// plus directed literal checks (RSP_LAT=1 main instance, RSP_LAT=3 latency instance).
module tb_cmd_arb;

  localparam int L = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_cmd0, req_cmd1;
  logic [1:0]  req_ready;
  logic        run;
  logic [31:0] cmd;
  logic [31:0] rsp;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_ack;
  logic        busy;
  logic [15:0] err_cnt;

  logic [1:0]  v3, rdy3, rv3, ack3;
  logic [31:0] c3a, c3b, cmd3, rsp3, rd3;
  logic        run3, busy3;
  logic [15:0] err3;

  always #5 clk = ~clk;

  // Target decoder echoes the command back as its response.
  assign rsp = cmd;

  cmd_arb #(.RSP_LAT(L), .ERR_BIT(31)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd0(req_cmd0),
    .req_cmd1(req_cmd1), .req_ready(req_ready), .run(run), .cmd(cmd),
    .rsp(rsp), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ack(rsp_ack), .busy(busy), .err_cnt(err_cnt));

  cmd_arb #(.RSP_LAT(3), .ERR_BIT(31)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_cmd0(c3a),
    .req_cmd1(c3b), .req_ready(rdy3), .run(run3), .cmd(cmd3),
    .rsp(rsp3), .rsp_valid(rv3), .rsp_data(rd3),
    .rsp_ack(ack3), .busy(busy3), .err_cnt(err3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] q0[$], q1[$];
  int          glog[$];
  logic [1:0]  rdy_seen = 2'b00;
  int          run_cnt = 0;
  bit          ack_en = 1'b1;
  logic [1:0]  ack_man = 2'b00;
  bit          pre_tog = 1'b0;

  // Requesters: present queue head, hold until the accept strobe is seen.
  initial begin
    req_valid = 2'b00; req_cmd0 = '0; req_cmd1 = '0;
    forever begin
      @(posedge clk); #1;
      if (req_valid[0] && rdy_seen[0]) begin void'(q0.pop_front()); glog.push_back(0); end
      if (req_valid[1] && rdy_seen[1]) begin void'(q1.pop_front()); glog.push_back(1); end
      req_valid[0] = (q0.size() > 0);
      req_valid[1] = (q1.size() > 0);
      req_cmd0 = (q0.size() > 0) ? q0[0] : 32'h0;
      req_cmd1 = (q1.size() > 0) ? q1[0] : 32'h0;
    end
  end

  initial begin
    rsp_ack = 2'b00;
    forever begin
      @(posedge clk); #1;
      rsp_ack = ack_en ? rsp_valid : ack_man;
    end
  end

  // Model: a transaction is a grant timestamp t=0; run at t=1, capture at
  // t=L+1, response offered from t=L+2 until the owner acknowledges.
  initial begin
    bit          m_act, m_g, m_last, g, pre_seen;
    int          m_t;
    logic [31:0] m_cmd, m_data;
    logic [15:0] m_err;
    logic [1:0]  e_rdy, e_rv;
    bit          e_run, e_busy;
    m_act = 0; m_g = 0; m_last = 1; m_t = 0; m_cmd = 0; m_data = 0; m_err = 0;
    pre_seen = 0; g = 0;
    forever begin
      @(negedge clk);
      rdy_seen = req_ready;
      if (run) run_cnt++;
      if (rst) begin
        chk("ready_in_rst", {30'd0, req_ready}, 32'd0);
        m_act = 0; m_last = 1; m_t = 0; m_cmd = 0; m_data = 0; m_err = 0;
      end else begin
        if (pre_tog != pre_seen) begin pre_seen = pre_tog; m_err = 16'hFFFF; end
        e_rdy = 2'b00; e_rv = 2'b00; e_run = 0; e_busy = 0;
        if (!m_act) begin
          if (|req_valid) begin
            g = (req_valid == 2'b11) ? ~m_last : (req_valid[0] ? 1'b0 : 1'b1);
            e_rdy = g ? 2'b10 : 2'b01;
          end
        end else begin
          e_busy = 1;
          e_run  = (m_t == 1);
          if (m_t >= L + 2) e_rv = m_g ? 2'b10 : 2'b01;
        end
        chk("req_ready", {30'd0, req_ready}, {30'd0, e_rdy});
        chk("run", {31'd0, run}, {31'd0, e_run});
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, e_rv});
        chk("cmd", cmd, m_cmd);
        chk("rsp_data", rsp_data, m_data);
        chk("err_cnt", {16'd0, err_cnt}, {16'd0, m_err});
        if (!m_act) begin
          if (|req_valid) begin
            m_act = 1; m_t = 1; m_g = g; m_last = g;
            m_cmd = g ? req_cmd1 : req_cmd0;
          end
        end else begin
          if (m_t == L + 1) begin
            m_data = rsp;
            if (rsp[31] && m_err != 16'hFFFF) m_err = m_err + 16'd1;
          end
          if (m_t >= L + 2 && rsp_ack[m_g]) m_act = 0;
          else m_t++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    repeat (2) @(negedge clk);
    for (n = 0; n < 200; n++) begin
      if (q0.size() == 0 && q1.size() == 0 && req_valid == 2'b00 && !busy) break;
      @(negedge clk);
    end
    chk("idle_timeout", n, n < 200 ? n : 200 - 1);
  endtask

  task automatic do_reset();
    step(); rst = 1'b1;
    step(); step(); rst = 1'b0;
  endtask

  initial begin
    int          r0;
    logic [31:0] d0;
    int          n;
    rst = 1'b1;
    v3 = 2'b00; c3a = '0; c3b = '0; rsp3 = 32'h5; ack3 = 2'b00;
    step(); step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd", cmd, 32'h0);
    chk("rst_err", {16'd0, err_cnt}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_rv", {30'd0, rsp_valid}, 32'h0);

    // Latency instance, RSP_LAT=3: only the run+3 response may be captured.
    step(); v3 = 2'b01; c3a = 32'h55;
    @(negedge clk); chk("l3_ready", {30'd0, rdy3}, 32'h1);
    step(); v3 = 2'b00;
    @(negedge clk);
    chk("l3_run", {31'd0, run3}, 32'h1);
    chk("l3_cmd", cmd3, 32'h55);
    chk("l3_busy", {31'd0, busy3}, 32'h1);
    step(); @(negedge clk);
    chk("l3_run_off", {31'd0, run3}, 32'h0);
    chk("l3_rv_r1", {30'd0, rv3}, 32'h0);
    step();
    step(); rsp3 = 32'hA;
    @(negedge clk); chk("l3_rv_r3", {30'd0, rv3}, 32'h0);
    step(); rsp3 = 32'h5;
    @(negedge clk);
    chk("l3_rv", {30'd0, rv3}, 32'h1);
    chk("l3_data", rd3, 32'hA);
    chk("l3_err", {16'd0, err3}, 32'h0);
    ack3 = 2'b01;
    step(); ack3 = 2'b00;
    @(negedge clk);
    chk("l3_idle", {31'd0, busy3}, 32'h0);
    chk("l3_rv_clr", {30'd0, rv3}, 32'h0);
    chk("l3_hold", rd3, 32'hA);

    // Single request from host A.
    glog.delete(); r0 = run_cnt;
    q0.push_back(32'h0300_0001);
    wait_idle();
    chk("single_data", rsp_data, 32'h0300_0001);
    chk("single_gnt_n", glog.size(), 1);
    if (glog.size() > 0) chk("single_gnt", glog[0], 0);
    chk("single_runs", run_cnt - r0, 1);

    // Tie after reset: 0, 1, 0.
    do_reset();
    glog.delete(); r0 = run_cnt;
    @(negedge clk);
    q0.push_back(32'h100); q0.push_back(32'h102); q1.push_back(32'h101);
    wait_idle();
    chk("tie_gnt_n", glog.size(), 3);
    for (int i = 0; i < 3 && i < glog.size(); i++) chk("tie_gnt", glog[i], i % 2);
    chk("tie_runs", run_cnt - r0, 3);
    chk("tie_last", rsp_data, 32'h102);

    // Three error responses, then saturation from a preloaded count.
    q1.push_back(32'h8000_0011); q1.push_back(32'h8000_0012); q1.push_back(32'h8000_0013);
    wait_idle();
    chk("err_three", {16'd0, err_cnt}, 32'd3);
    step(); force dut.err_cnt = 16'hFFFF; pre_tog = ~pre_tog;
    step(); release dut.err_cnt;
    q1.push_back(32'h8000_0014);
    wait_idle();
    chk("err_sat", {16'd0, err_cnt}, 32'hFFFF);

    // Back-pressure with both requesting; stray ack on index 1 is ignored.
    glog.delete();
    ack_en = 0; ack_man = 2'b00;
    q0.push_back(32'h200); q1.push_back(32'h201);
    for (n = 0; n < 50 && rsp_valid != 2'b01; n++) @(negedge clk);
    chk("bp_reach", {30'd0, rsp_valid}, 32'h1);
    ack_man = 2'b10;
    d0 = rsp_data; r0 = run_cnt;
    repeat (10) @(negedge clk);
    chk("bp_rv", {30'd0, rsp_valid}, 32'h1);
    chk("bp_data", rsp_data, 32'h200);
    chk("bp_steady", rsp_data, d0);
    chk("bp_runs", run_cnt - r0, 0);
    chk("bp_busy", {31'd0, busy}, 32'h1);
    ack_man = 2'b00; ack_en = 1;
    wait_idle();
    chk("bp_gnt_n", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("bp_gnt0", glog[0], 0);
      chk("bp_gnt1", glog[1], 1);
    end

    // Reset while waiting for the response aborts the command.
    q0.push_back(32'h300);
    for (n = 0; n < 20 && !run; n++) @(negedge clk);
    chk("wr_run", {31'd0, run}, 32'h1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("wr_busy", {31'd0, busy}, 32'h0);
    chk("wr_rv", {30'd0, rsp_valid}, 32'h0);
    chk("wr_err", {16'd0, err_cnt}, 32'h0);
    glog.delete();
    q1.push_back(32'h400);
    wait_idle();
    chk("wr_after", rsp_data, 32'h400);
    chk("wr_gnt_n", glog.size(), 1);
    if (glog.size() > 0) chk("wr_gnt", glog[0], 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
